apb_initiator: RTL and testbench
================================

APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 Parameter AddrWidth, default 8, APB address width in bits.
REQ-002 Parameter TimeoutCycles, default 255, maximum wait-state count in ACCESS; 0 disables the timeout.
REQ-003 PCLK  input  1  clock; all logic on rising edge.
REQ-004 PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 req_addr  input  AddrWidth  target byte address.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-013 rsp_err  output  1  PSLVERR seen or timeout.
REQ-014 rsp_timeout  output  1  transfer aborted by timeout.
REQ-015 PSEL, PENABLE, PWRITE  output  1 each  APB controls.
REQ-016 PADDR  output  AddrWidth; PWDATA  output  32  APB address and write data.
REQ-017 PRDATA  input  32; PREADY  input  1; PSLVERR  input  1  APB completer response.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS, RESP; exactly one transfer outstanding.
REQ-019 req_ready = 1 only in IDLE; on req_valid & req_ready, latch addr/write/wdata and go to SETUP.
REQ-020 SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS unconditionally.
REQ-021 ACCESS: PSEL=1, PENABLE=1; stay while PREADY=0.
REQ-022 PADDR, PWRITE, PWDATA driven from latched request and stable from SETUP through the last ACCESS cycle; they hold their last value outside transfers.
REQ-023 ACCESS with PREADY=1: capture PRDATA (read) or 0 (write) into rsp_rdata, PSLVERR into rsp_err, rsp_timeout=0, go to RESP.
REQ-024 Wait counter clears on SETUP and increments each ACCESS cycle with PREADY=0; when TimeoutCycles != 0 and count reaches TimeoutCycles with PREADY still 0, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-025 PREADY=1 in the same cycle the count reaches its limit completes normally; completion wins over timeout.
REQ-026 RESP: PSEL=0, PENABLE=0, rsp_valid=1; rsp_* held stable until rsp_ready=1, then go to IDLE.
REQ-027 Zero-wait latency: acceptance edge N; SETUP in cycle N+1; ACCESS in N+2; rsp_valid in N+3; next acceptance no earlier than one IDLE cycle after the RESP handshake.
REQ-028 PSEL/PENABLE are never 1 in IDLE or RESP; PENABLE never 1 without PSEL.
REQ-029 Counter width is clog2(TimeoutCycles+1), minimum 1; it never wraps.

Reset
REQ-030 PRESETn low asynchronously forces IDLE and zeroes PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the counter; req_ready=1 once reset deasserts.
REQ-031 Reset mid-transfer drops the transfer with no response generated.

Structure
REQ-032 Package apb_initiator_pkg holds the 2-bit state encodings (IDLE=0, SETUP=1, ACCESS=2, RESP=3) and the default TimeoutCycles constant.
REQ-033 The wait counter is a sub-module apb_wait_timer (inputs clear, enable; output expired).

Verification
REQ-034 Read 0x04 with PREADY=1 and PRDATA=0x000000A5 -> PSEL high 2 cycles, PENABLE high 1 cycle; rsp_valid 3 cycles after acceptance; rsp_rdata=0x000000A5, rsp_err=0.
REQ-035 Write 0x08 with wdata 0x0000003C, PREADY low 4 cycles -> PADDR/PWDATA stable for 6 cycles; rsp_rdata=0, rsp_err=0.
REQ-036 Read with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
REQ-037 TimeoutCycles=3, PREADY held 0 -> RESP after 3 ACCESS wait cycles with rsp_err=1, rsp_timeout=1; PREADY=1 on the 3rd wait cycle -> normal completion.
REQ-038 rsp_ready held 0 for 5 cycles with req_valid=1 -> rsp_* stable and req_ready=0; PRESETn pulsed during ACCESS -> PSEL=0 immediately, no rsp_valid.

Source files
------------

// File: rtl/apb_initiator_pkg.sv
// Shared state encodings and defaults for the APB initiator and its wait timer.
package apb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apbState_t;

    localparam int DefaultTimeoutCycles = 255;

    // Bits needed to hold 0..limit, never less than one bit
    function automatic int counterWidth(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_initiator_wait_timer.sv
// Saturating ACCESS wait-state counter; flags the wait cycle that reaches the timeout limit.
module apb_wait_timer
    import apb_initiator_pkg::*;
#(
    parameter int TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CntW = counterWidth(TimeoutCycles);
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
    localparam logic [CntW-1:0] LastWait =
        (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] waitCount;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            waitCount <= '0;
        end else if (clear) begin
            waitCount <= '0;
        end else if (enable && (waitCount != CntMax)) begin
            waitCount <= waitCount + 1'b1;
        end
    end

    // High when the current wait cycle is the one that brings the count to the limit;
    // the caller qualifies it with its own enable so no combinational loop forms
    assign expired = (TimeoutCycles != 0) && (waitCount == LastWait);

endmodule

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: request/response handshake in, APB SETUP/ACCESS out.
module apb_initiator
    import apb_initiator_pkg::*;
#(
    parameter int AddrWidth     = 8,
    parameter int TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic                 req_write,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [AddrWidth-1:0] PADDR,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    apbState_t state;
    apbState_t nextState;
    logic      accept;
    logic      timerClear;
    logic      timerEnable;
    logic      timerLast;
    logic      completeOk;
    logic      completeTimeout;

    assign accept = req_valid && req_ready;

    apb_wait_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) waitTimer (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .clear  (timerClear),
        .enable (timerEnable),
        .expired(timerLast)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState       = state;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        PSEL            = 1'b0;
        PENABLE         = 1'b0;
        timerClear      = 1'b0;
        timerEnable     = 1'b0;
        completeOk      = 1'b0;
        completeTimeout = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nextState = SETUP;
                end
            end
            SETUP: begin
                PSEL       = 1'b1;
                timerClear = 1'b1;
                nextState  = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // A ready completer always wins over an expiring timer
                if (PREADY) begin
                    completeOk = 1'b1;
                    nextState  = RESP;
                end else begin
                    timerEnable = 1'b1;
                    if (timerLast) begin
                        completeTimeout = 1'b1;
                        nextState       = RESP;
                    end
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // APB address/data come only from the latched request and hold between transfers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (accept) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (completeOk) begin
            rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (completeTimeout) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_initiator.sv
// Randomised self-checking bench: a default-timeout and a short-timeout initiator against a transaction-level model.
module tb_apb_initiator;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad = 0;

    // sel picks which instance the tasks drive and observe: 0 = default timeout, 1 = timeout of 3
    logic        sel = 1'b0;
    logic        reqValid = 1'b0;
    logic [7:0]  reqAddr = '0;
    logic        reqWrite = 1'b0;
    logic [31:0] reqWdata = '0;
    logic        rspReady = 1'b0;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    logic        reqReadyA, rspValidA, rspErrA, rspTimeoutA, pselA, penableA, pwriteA;
    logic [31:0] rspRdataA, pwdataA;
    logic [7:0]  paddrA;
    logic        reqReadyB, rspValidB, rspErrB, rspTimeoutB, pselB, penableB, pwriteB;
    logic [31:0] rspRdataB, pwdataB;
    logic [7:0]  paddrB;
    logic        reqValidA, reqValidB;

    assign reqValidA = reqValid & ~sel;
    assign reqValidB = reqValid & sel;

    logic        reqReady, rspValid, rspErr, rspTimeout, psel, penable, pwrite;
    logic [31:0] rspRdata, pwdata;
    logic [7:0]  paddr;
    assign reqReady   = sel ? reqReadyB   : reqReadyA;
    assign rspValid   = sel ? rspValidB   : rspValidA;
    assign rspErr     = sel ? rspErrB     : rspErrA;
    assign rspTimeout = sel ? rspTimeoutB : rspTimeoutA;
    assign rspRdata   = sel ? rspRdataB   : rspRdataA;
    assign psel       = sel ? pselB       : pselA;
    assign penable    = sel ? penableB    : penableA;
    assign pwrite     = sel ? pwriteB     : pwriteA;
    assign pwdata     = sel ? pwdataB     : pwdataA;
    assign paddr      = sel ? paddrB      : paddrA;

    apb_initiator dutA (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(reqValidA), .req_ready(reqReadyA), .req_addr(reqAddr),
        .req_write(reqWrite), .req_wdata(reqWdata),
        .rsp_valid(rspValidA), .rsp_ready(rspReady), .rsp_rdata(rspRdataA),
        .rsp_err(rspErrA), .rsp_timeout(rspTimeoutA),
        .PSEL(pselA), .PENABLE(penableA), .PWRITE(pwriteA), .PADDR(paddrA), .PWDATA(pwdataA),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_initiator #(.AddrWidth(8), .TimeoutCycles(3)) dutB (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(reqValidB), .req_ready(reqReadyB), .req_addr(reqAddr),
        .req_write(reqWrite), .req_wdata(reqWdata),
        .rsp_valid(rspValidB), .rsp_ready(rspReady), .rsp_rdata(rspRdataB),
        .rsp_err(rspErrB), .rsp_timeout(rspTimeoutB),
        .PSEL(pselB), .PENABLE(penableB), .PWRITE(pwriteB), .PADDR(paddrB), .PWDATA(pwdataB),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    // Protocol rule watched every cycle on both instances
    always @(negedge PCLK) begin
        if (PRESETn) begin
            total++;
            if ((penableA && !pselA) || (penableB && !pselB) ||
                (pselA && (rspValidA || reqReadyA)) || (pselB && (rspValidB || reqReadyB))) begin
                bad++;
                $display("[TB] FAIL protocol got pselA=%b penA=%b pselB=%b penB=%b required psel only outside IDLE/RESP",
                         pselA, penableA, pselB, penableB);
            end
        end
    end

    // Transaction-level reference: how many ACCESS cycles happen and what the response carries
    function automatic void model(input int tmo, input logic wr, input logic [31:0] rd, input int waits,
                                  input logic slv, output int eLat, output int ePsel, output int ePen,
                                  output logic [31:0] eRdata, output logic eErr, output logic eTo);
        int accessCycles;
        if (tmo != 0 && waits >= tmo) begin
            accessCycles = tmo;
            eRdata = 32'h0; eErr = 1'b1; eTo = 1'b1;
        end else begin
            accessCycles = waits + 1;
            eRdata = wr ? 32'h0 : rd; eErr = slv; eTo = 1'b0;
        end
        eLat = 2 + accessCycles;
        ePsel = 1 + accessCycles;
        ePen = accessCycles;
    endfunction

    // Completer behaviour: hold PREADY low for 'waits' ACCESS cycles; collects observations only
    task automatic runTxn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits, input logic slv, input int rspDelay,
                          output int lat, output int pselCnt, output int penCnt, output logic stableOk,
                          output logic [31:0] oRdata, output logic oErr, output logic oTo,
                          output logic holdOk, output logic idleOk);
        int accessCnt;
        accessCnt = 0;
        lat = 1; pselCnt = 0; penCnt = 0; stableOk = 1'b1; holdOk = 1'b1; idleOk = 1'b1;
        reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wd; rspReady = 1'b0;
        @(posedge PCLK); #1;
        reqValid = 1'b0; reqAddr = 8'($urandom); reqWdata = $urandom; reqWrite = 1'($urandom);
        while (!rspValid && lat <= 400) begin
            if (psel) begin
                pselCnt++;
                if (paddr !== addr || pwrite !== wr || pwdata !== wd) stableOk = 1'b0;
            end
            if (penable) penCnt++;
            if (psel && penable) begin
                accessCnt++;
                pready = (accessCnt > waits);
                prdata = pready ? rd : $urandom;
                pslverr = pready ? slv : 1'($urandom);
            end else begin
                pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
            end
            @(posedge PCLK); #1;
            lat++;
        end
        pready = 1'b0;
        oRdata = rspRdata; oErr = rspErr; oTo = rspTimeout;
        for (int d = 0; d < rspDelay; d++) begin
            reqValid = 1'b1;
            @(posedge PCLK); #1;
            if (!rspValid || reqReady || psel || penable ||
                rspRdata !== oRdata || rspErr !== oErr || rspTimeout !== oTo) holdOk = 1'b0;
        end
        reqValid = 1'b0; rspReady = 1'b1;
        @(posedge PCLK); #1;
        rspReady = 1'b0;
        if (rspValid || !reqReady || psel) idleOk = 1'b0;
        if (paddr !== addr || pwrite !== wr || pwdata !== wd) stableOk = 1'b0;
    endtask

    task automatic test_reset();
        logic [81:0] obsA, obsB;
        #12;
        obsA = {pselA, penableA, pwriteA, paddrA, pwdataA, rspValidA, rspRdataA, rspErrA, rspTimeoutA};
        obsB = {pselB, penableB, pwriteB, paddrB, pwdataB, rspValidB, rspRdataB, rspErrB, rspTimeoutB};
        total++;
        if (obsA !== '0 || obsB !== '0) begin
            bad++; $display("[TB] FAIL reset_outputs got A=%h B=%h required 0", obsA, obsB);
        end
        #4 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        total++;
        if (reqReadyA !== 1'b1 || reqReadyB !== 1'b1 || rspValidA !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_ready got A=%b B=%b required 1", reqReadyA, reqReadyB);
        end
    endtask

    task automatic test_zero_wait_read();
        int lat, ps, pe; logic st, hOk, iOk, err, to; logic [31:0] rdt;
        sel = 1'b0;
        runTxn(1'b0, 8'h04, 32'h0, 32'h0000_00A5, 0, 1'b0, 0, lat, ps, pe, st, rdt, err, to, hOk, iOk);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL read_latency got=%0d required=3", lat); end
        total++; if (ps !== 2 || pe !== 1) begin bad++; $display("[TB] FAIL read_strobes got psel=%0d pen=%0d required 2/1", ps, pe); end
        total++; if (rdt !== 32'hA5 || err !== 1'b0 || to !== 1'b0) begin
            bad++; $display("[TB] FAIL read_rsp got rdata=%h err=%b to=%b required a5/0/0", rdt, err, to); end
        total++; if (!st || !iOk) begin bad++; $display("[TB] FAIL read_stable got stable=%b idle=%b required 1/1", st, iOk); end
    endtask

    task automatic test_wait_write();
        int lat, ps, pe; logic st, hOk, iOk, err, to; logic [31:0] rdt;
        sel = 1'b0;
        runTxn(1'b1, 8'h08, 32'h0000_003C, 32'hDEAD_BEEF, 4, 1'b0, 0, lat, ps, pe, st, rdt, err, to, hOk, iOk);
        total++; if (ps !== 6 || lat !== 7) begin bad++; $display("[TB] FAIL write_waits got psel=%0d lat=%0d required 6/7", ps, lat); end
        total++; if (!st) begin bad++; $display("[TB] FAIL write_stable got=%b required=1", st); end
        total++; if (rdt !== 32'h0 || err !== 1'b0 || to !== 1'b0) begin
            bad++; $display("[TB] FAIL write_rsp got rdata=%h err=%b to=%b required 0/0/0", rdt, err, to); end
    endtask

    task automatic test_slverr();
        int lat, ps, pe, w; logic st, hOk, iOk, err, to; logic [31:0] rdt, rd;
        sel = 1'b0;
        w = $urandom_range(3, 0); rd = $urandom;
        runTxn(1'b0, 8'h10, 32'h0, rd, w, 1'b1, 0, lat, ps, pe, st, rdt, err, to, hOk, iOk);
        total++; if (err !== 1'b1 || to !== 1'b0 || rdt !== rd) begin
            bad++; $display("[TB] FAIL slverr_rsp got err=%b to=%b rdata=%h required 1/0/%h", err, to, rdt, rd); end
    endtask

    task automatic test_timeout();
        int lat, ps, pe, eLat, ePs, ePe; logic st, hOk, iOk, err, to, eErr, eTo; logic [31:0] rdt, eRd;
        int waitList [4] = '{10, 3, 2, 0};
        sel = 1'b1;
        foreach (waitList[i]) begin
            logic wr; logic [31:0] rd;
            wr = 1'(i % 2); rd = $urandom;
            model(3, wr, rd, waitList[i], 1'b0, eLat, ePs, ePe, eRd, eErr, eTo);
            runTxn(wr, 8'($urandom), $urandom, rd, waitList[i], 1'b0, 0, lat, ps, pe, st, rdt, err, to, hOk, iOk);
            total++; if (lat !== eLat || pe !== ePe) begin
                bad++; $display("[TB] FAIL timeout_latency waits=%0d got lat=%0d pen=%0d required %0d/%0d", waitList[i], lat, pe, eLat, ePe); end
            total++; if (rdt !== eRd || err !== eErr || to !== eTo) begin
                bad++; $display("[TB] FAIL timeout_rsp waits=%0d got %h/%b/%b required %h/%b/%b", waitList[i], rdt, err, to, eRd, eErr, eTo); end
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat, ps, pe; logic st, hOk, iOk, err, to; logic [31:0] rdt;
        sel = 1'b0;
        runTxn(1'b0, 8'h20, 32'h0, 32'h1234_5678, 1, 1'b0, 5, lat, ps, pe, st, rdt, err, to, hOk, iOk);
        total++; if (!hOk) begin bad++; $display("[TB] FAIL backpressure_hold got=%b required=1", hOk); end
        total++; if (!iOk || rdt !== 32'h1234_5678) begin
            bad++; $display("[TB] FAIL backpressure_release got idle=%b rdata=%h required 1/12345678", iOk, rdt); end
    endtask

    task automatic test_random();
        int lat, ps, pe, eLat, ePs, ePe, w, tmo; logic st, hOk, iOk, err, to, eErr, eTo, wr, slv;
        logic [31:0] rdt, eRd, rd;
        for (int n = 0; n < 32; n++) begin
            sel = (n >= 24);
            tmo = sel ? 3 : 255;
            w = $urandom_range(6, 0); wr = 1'($urandom); slv = 1'($urandom); rd = $urandom;
            model(tmo, wr, rd, w, slv, eLat, ePs, ePe, eRd, eErr, eTo);
            runTxn(wr, 8'($urandom), $urandom, rd, w, slv, $urandom_range(3, 0), lat, ps, pe, st, rdt, err, to, hOk, iOk);
            total++; if (lat !== eLat || ps !== ePs || pe !== ePe) begin
                bad++; $display("[TB] FAIL random_timing n=%0d got %0d/%0d/%0d required %0d/%0d/%0d", n, lat, ps, pe, eLat, ePs, ePe); end
            total++; if (rdt !== eRd || err !== eErr || to !== eTo) begin
                bad++; $display("[TB] FAIL random_rsp n=%0d got %h/%b/%b required %h/%b/%b", n, rdt, err, to, eRd, eErr, eTo); end
            total++; if (!st || !hOk || !iOk) begin
                bad++; $display("[TB] FAIL random_hold n=%0d got stable=%b hold=%b idle=%b required 1/1/1", n, st, hOk, iOk); end
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, ps, pe; logic st, hOk, iOk, err, to; logic [31:0] rdt, rd;
        sel = 1'b0;
        for (int n = 0; n < 4; n++) begin
            rd = $urandom;
            runTxn(1'b0, 8'(4 * n), 32'h0, rd, 0, 1'b0, 0, lat, ps, pe, st, rdt, err, to, hOk, iOk);
            total++; if (lat !== 3 || rdt !== rd || !iOk) begin
                bad++; $display("[TB] FAIL back_to_back n=%0d got lat=%0d rdata=%h idle=%b required 3/%h/1", n, lat, rdt, iOk, rd); end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        logic sawRsp;
        sel = 1'b0;
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 8'h3C; reqWdata = 32'hCAFE_0001; pready = 1'b0;
        @(posedge PCLK); #1;
        reqValid = 1'b0;
        guard = 0;
        while (!(psel && penable) && guard < 20) begin
            @(posedge PCLK); #1;
            guard++;
        end
        total++; if (guard >= 20) begin bad++; $display("[TB] FAIL reset_mid_access got no ACCESS within %0d cycles", guard); end
        #2 PRESETn = 1'b0;
        #1;
        total++; if (psel !== 1'b0 || penable !== 1'b0 || rspValid !== 1'b0 || paddr !== 8'h0 || pwdata !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_mid_drop got psel=%b pen=%b rspv=%b paddr=%h required 0/0/0/00", psel, penable, rspValid, paddr); end
        #3 PRESETn = 1'b1;
        pready = 1'b1;
        sawRsp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge PCLK); #1;
            if (rspValid || psel || !reqReady) sawRsp = 1'b1;
        end
        pready = 1'b0;
        total++; if (sawRsp) begin bad++; $display("[TB] FAIL reset_mid_after got activity=%b required 0", sawRsp); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
